// File: rtl/reg_share_arbiter.sv
// -----------------------------------------------------------------------------
// reg_share_arbiter
//
// Purpose:
//   This block shares one WIDTH-bit register bank between NREQ requesters.
//   The bank is a plain D flip-flop bank with no enable, so this block drives
//   its D input on every cycle. When nobody writes, D is fed back from Q.
//   When the current owner writes, D takes that owner's data.
//   Ownership is decided by a round-robin arbiter. Each ownership lasts at
//   most MAX_HOLD cycles, so one requester cannot starve the others.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous reset, active low (0 = reset)
//   req      in   NREQ        per-requester ownership request (level)
//   wr       in   NREQ        per-requester write strobe (owner only, GRANT only)
//   wdata    in   NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//   reg_q    in   WIDTH       register bank Q
//   reg_d    out  WIDTH       register bank D (combinational)
//   gnt      out  NREQ        one-hot grant (registered)
//   busy     out  1           high while an ownership is active (registered)
//   timeout  out  1           one-cycle pulse after a forced release (registered)
// -----------------------------------------------------------------------------
module reg_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         wr,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    input  logic [WIDTH-1:0]        reg_q,
    output logic [WIDTH-1:0]        reg_d,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    timeout
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              state_q;
    logic [OW-1:0]       owner_q;
    logic [OW-1:0]       ptr_q;
    logic [HW-1:0]       hold_cnt_q;
    logic [NREQ-1:0]     gnt_q;
    logic                busy_q;
    logic                timeout_q;

    logic                sel_valid;
    logic [OW-1:0]       sel_idx;
    logic [NREQ-1:0]     sel_onehot;

    // Split the flat write-data bus into one slice per requester.
    logic [WIDTH-1:0]    wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_wdata_split
            assign wdata_arr[gi] = wdata[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search. It starts one position after the last owner.
    // The loop walks from the farthest candidate to the nearest one.
    // Because each hit overwrites the previous one, the last hit kept is the
    // first set bit in rotation order. This avoids an early exit from the loop.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr_q) + k) % NREQ]) begin
                sel_valid = 1'b1;
                sel_idx   = OW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    assign sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;

    // Arbitration FSM. All of its outputs are registered.
    // A release always lands in IDLE. That gives at least one cycle with
    // gnt=0 before the next grant, even when the same requester asks again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= OW'(NREQ - 1);
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timeout_q <= 1'b0;
                    if (sel_valid) begin
                        state_q    <= ST_GRANT;
                        owner_q    <= sel_idx;
                        ptr_q      <= sel_idx;
                        hold_cnt_q <= HW'(1);
                        gnt_q      <= sel_onehot;
                        busy_q     <= 1'b1;
                    end else begin
                        gnt_q      <= '0;
                        busy_q     <= 1'b0;
                    end
                end

                ST_GRANT: begin
                    if (!req[owner_q]) begin
                        // Voluntary release.
                        state_q    <= ST_IDLE;
                        gnt_q      <= '0;
                        busy_q     <= 1'b0;
                        hold_cnt_q <= '0;
                        timeout_q  <= 1'b0;
                    end else if (hold_cnt_q == HW'(MAX_HOLD)) begin
                        // The owner still requests, but its hold budget is spent.
                        state_q    <= ST_IDLE;
                        gnt_q      <= '0;
                        busy_q     <= 1'b0;
                        hold_cnt_q <= '0;
                        timeout_q  <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                        timeout_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= ST_IDLE;
                    gnt_q      <= '0;
                    busy_q     <= 1'b0;
                    hold_cnt_q <= '0;
                    timeout_q  <= 1'b0;
                end
            endcase
        end
    end

    // Write path. A write is taken only from the owner while in GRANT.
    // This includes the owner's final cycle. In every other case the bank
    // simply keeps its current value.
    always_comb begin
        reg_d = reg_q;
        if ((state_q == ST_GRANT) && wr[owner_q]) begin
            reg_d = wdata_arr[owner_q];
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_share_arbiter
//
// Purpose:
//   Directed bench for reg_share_arbiter with NREQ=4 and WIDTH=4.
//   The main instance uses MAX_HOLD=8.
//   A second instance uses MAX_HOLD=1 and shares the same stimulus.
//   The register bank is modelled locally, and its Q is fed back to reg_q.
// -----------------------------------------------------------------------------
module tb_reg_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [15:0] wdata;
    logic [3:0]  reg_q;
    logic [3:0]  reg_d;
    logic [3:0]  gnt;
    logic        busy;
    logic        timeout;

    logic [3:0]  reg_d1;
    logic [3:0]  gnt1;
    logic        busy1;
    logic        timeout1;

    // Register bank model. Its active-high reset is driven from ~reset.
    // ext_q_en lets the bench force reg_q directly.
    logic [3:0]  bank_q;
    logic [3:0]  ext_q;
    logic        ext_q_en;

    assign reg_q = ext_q_en ? ext_q : bank_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bank_q <= '0;
        else        bank_q <= reg_d;
    end

    reg_share_arbiter #(.NREQ(4), .WIDTH(4), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr      (wr),
        .wdata   (wdata),
        .reg_q   (reg_q),
        .reg_d   (reg_d),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    reg_share_arbiter #(.NREQ(4), .WIDTH(4), .MAX_HOLD(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr      (wr),
        .wdata   (wdata),
        .reg_q   (reg_q),
        .reg_d   (reg_d1),
        .gnt     (gnt1),
        .busy    (busy1),
        .timeout (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req   = '0;
        wr    = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [15:0] wdata;
        logic [3:0]  gnt;
        logic        to;
        logic [3:0]  rd;
    } vec_t;

    vec_t vecs [25];

    // Absolute watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hi_cnt;
        logic seen;
        logic [3:0] exp_g;
        logic       exp_to;

        // Each vector is: req, wr, wdata, then the expected gnt, timeout and reg_d.
        // The checks run at the vector's own cycle, after the inputs are applied.
        // Single requester 2 writes 0xA on its 2nd GRANT cycle, then releases.
        vecs[0]  = '{4'b0100, 4'b0000, 16'h0A00, 4'b0000, 1'b0, 4'h0};
        vecs[1]  = '{4'b0100, 4'b0000, 16'h0A00, 4'b0100, 1'b0, 4'h0};
        vecs[2]  = '{4'b0100, 4'b0100, 16'h0A00, 4'b0100, 1'b0, 4'hA};
        vecs[3]  = '{4'b0000, 4'b0000, 16'h0A00, 4'b0100, 1'b0, 4'hA};
        vecs[4]  = '{4'b0000, 4'b0000, 16'h0A00, 4'b0000, 1'b0, 4'hA};
        // Owner 0: the non-owner write is ignored.
        // Then the owner drops req and writes in the same cycle.
        // Then a write arriving in IDLE is ignored.
        vecs[5]  = '{4'b0001, 4'b0000, 16'hF000, 4'b0000, 1'b0, 4'hA};
        vecs[6]  = '{4'b0001, 4'b1000, 16'hF000, 4'b0001, 1'b0, 4'hA};
        vecs[7]  = '{4'b0000, 4'b0001, 16'hF005, 4'b0001, 1'b0, 4'h5};
        vecs[8]  = '{4'b0000, 4'b0001, 16'h0007, 4'b0000, 1'b0, 4'h5};
        // Rotation with all requesters active, starting from ptr=0.
        // The grant order is 1,2,3,0,1 (this covers the pointer wrap).
        vecs[9]  = '{4'b1111, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'h5};
        vecs[10] = '{4'b1111, 4'b0000, 16'h0000, 4'b0010, 1'b0, 4'h5};
        vecs[11] = '{4'b1101, 4'b0000, 16'h0000, 4'b0010, 1'b0, 4'h5};
        vecs[12] = '{4'b1111, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'h5};
        vecs[13] = '{4'b1111, 4'b0000, 16'h0000, 4'b0100, 1'b0, 4'h5};
        vecs[14] = '{4'b1011, 4'b0000, 16'h0000, 4'b0100, 1'b0, 4'h5};
        vecs[15] = '{4'b1111, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'h5};
        vecs[16] = '{4'b1111, 4'b0000, 16'h0000, 4'b1000, 1'b0, 4'h5};
        vecs[17] = '{4'b0111, 4'b0000, 16'h0000, 4'b1000, 1'b0, 4'h5};
        vecs[18] = '{4'b1111, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'h5};
        vecs[19] = '{4'b1111, 4'b0000, 16'h0000, 4'b0001, 1'b0, 4'h5};
        vecs[20] = '{4'b1110, 4'b0000, 16'h0000, 4'b0001, 1'b0, 4'h5};
        vecs[21] = '{4'b1111, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'h5};
        vecs[22] = '{4'b1111, 4'b0000, 16'h0000, 4'b0010, 1'b0, 4'h5};
        vecs[23] = '{4'b0000, 4'b0000, 16'h0000, 4'b0010, 1'b0, 4'h5};
        vecs[24] = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 1'b0, 4'h5};

        // ---- Reset state ----
        // Hold reset with all requests high and a forced reg_q.
        reset    = 1'b0;
        req      = 4'b1111;
        wr       = '0;
        wdata    = '0;
        ext_q_en = 1'b1;
        ext_q    = 4'h9;
        repeat (2) @(negedge clk);
        #1;
        check("reset_gnt",     32'(gnt),     32'h0);
        check("reset_busy",    32'(busy),    32'h0);
        check("reset_timeout", 32'(timeout), 32'h0);
        check("reset_reg_d",   32'(reg_d),   32'h9);
        $display("reset: gnt=%b busy=%b timeout=%b reg_d=%h", gnt, busy, timeout, reg_d);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("first_grant",   32'(gnt),  32'b0001);
        check("first_grant_h1", 32'(gnt1), 32'b0001);
        $display("after reset release: gnt=%b", gnt);
        ext_q_en = 1'b0;

        // ---- Table-driven vectors ----
        do_reset();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            req   = vecs[i].req;
            wr    = vecs[i].wr;
            wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_gnt", i),     32'(gnt),     32'(vecs[i].gnt));
            check($sformatf("vec%0d_busy", i),    32'(busy),    32'(|vecs[i].gnt));
            check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vecs[i].to));
            check($sformatf("vec%0d_reg_d", i),   32'(reg_d),   32'(vecs[i].rd));
            $display("vec %0d: req=%b wr=%b wdata=%h gnt=%b busy=%b timeout=%b reg_d=%h",
                     i, req, wr, wdata, gnt, busy, timeout, reg_d);
        end

        // ---- Forced release: requester 1 holds req for 20 cycles ----
        // With MAX_HOLD=8 the pattern repeats every 9 cycles:
        // one IDLE cycle, then 8 GRANT cycles.
        // With MAX_HOLD=1 it repeats every 2 cycles.
        do_reset();
        hi_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            req = 4'b0010;
            wr  = 4'b0000;
            #1;
            exp_g  = ((c % 9) != 0) ? 4'b0010 : 4'b0000;
            exp_to = (c > 0) && ((c % 9) == 0);
            check($sformatf("hold8_c%0d_gnt", c),     32'(gnt),     32'(exp_g));
            check($sformatf("hold8_c%0d_timeout", c), 32'(timeout), 32'(exp_to));
            exp_g  = ((c % 2) != 0) ? 4'b0010 : 4'b0000;
            exp_to = (c > 0) && ((c % 2) == 0);
            check($sformatf("hold1_c%0d_gnt", c),     32'(gnt1),     32'(exp_g));
            check($sformatf("hold1_c%0d_timeout", c), 32'(timeout1), 32'(exp_to));
            if (c < 9 && gnt[1]) hi_cnt++;
            $display("hold c=%0d: gnt=%b timeout=%b gnt_h1=%b timeout_h1=%b",
                     c, gnt, timeout, gnt1, timeout1);
        end
        check("hold8_first_grant_len", 32'(hi_cnt), 32'd8);

        // ---- Asynchronous reset in the middle of a grant ----
        do_reset();
        @(negedge clk);
        req  = 4'b0100;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (gnt == 4'b0100) seen = 1'b1;
        end
        check("async_wait_grant", 32'(seen), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_gnt",  32'(gnt),  32'h0);
        check("async_busy", 32'(busy), 32'h0);
        $display("async reset mid-grant: gnt=%b busy=%b", gnt, busy);
        @(negedge clk);
        reset = 1'b1;
        req   = 4'b0101;
        @(negedge clk);
        #1;
        check("async_regrant", 32'(gnt), 32'b0001);
        $display("after async reset, req=0101: gnt=%b", gnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
